network_receiver: RTL and testbench

Receive-side deserializer for the inter-board link. It consumes the header lane and four data lanes driven by the peer board's sender over GPIO and hunts for a sync pattern. It decodes the packet type and sequence bit, reassembles the data payload and checks per-lane parity. It then hands control events (ACK, ready, game-lost) and validated game-state payloads to the game logic.

---
 rtl/network_receiver.sv | 166 ++++++++++++++++
 tb/tb_network_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/network_receiver.sv
// Inter-board link deserializer: sync hunt, header decode, 4-lane payload reassembly with per-lane parity.
// Latency: control/unknown pulses at sync+5, DATA pulses at sync+6+DATA_CYCLES. No backpressure: payload must be taken on pkt_valid.
module network_receiver #(
    parameter int          DATA_CYCLES = 160,
    parameter logic [3:0]  SYNC        = 4'b1011
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       serial_in_h,
    input  logic                       serial_in_0,
    input  logic                       serial_in_1,
    input  logic                       serial_in_2,
    input  logic                       serial_in_3,
    output logic                       pkt_valid,
    output logic [2:0]                 pkt_type,
    output logic                       pkt_seq,
    output logic                       pkt_err,
    output logic                       data_dup,
    output logic [4*DATA_CYCLES-1:0]   payload,
    output logic                       ack_received,
    output logic                       ack_seqNum,
    output logic                       ready_received,
    output logic                       game_lost_received,
    output logic                       rx_busy
);

    localparam int PW = 4 * DATA_CYCLES;
    localparam int CW = ($clog2(DATA_CYCLES) < 2) ? 2 : $clog2(DATA_CYCLES);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_PARITY  = 2'd3;

    localparam logic [2:0] T_ACK   = 3'b001;
    localparam logic [2:0] T_READY = 3'b010;
    localparam logic [2:0] T_LOST  = 3'b011;
    localparam logic [2:0] T_DATA  = 3'b100;

    localparam logic [CW-1:0] HDR_LAST = CW'(3);
    localparam logic [CW-1:0] PAY_LAST = CW'(DATA_CYCLES - 1);

    logic [1:0]    state;
    logic [3:0]    sync_sr;
    logic [CW-1:0] cnt;
    logic [2:0]    hdr_type;
    logic          hdr_seq;
    logic [PW-1:0] staging;
    logic [3:0]    lane_par;
    logic          have_data;
    logic          last_data_seq;

    logic [3:0] lanes;
    logic [3:0] sync_next;

    assign lanes     = {serial_in_3, serial_in_2, serial_in_1, serial_in_0};
    assign sync_next = {sync_sr[2:0], serial_in_h};
    assign rx_busy   = (state != S_HUNT);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state              <= S_HUNT;
            sync_sr            <= 4'd0;
            cnt                <= '0;
            hdr_type           <= 3'd0;
            hdr_seq            <= 1'b0;
            staging            <= '0;
            lane_par           <= 4'd0;
            have_data          <= 1'b0;
            last_data_seq      <= 1'b0;
            pkt_valid          <= 1'b0;
            pkt_type           <= 3'd0;
            pkt_seq            <= 1'b0;
            pkt_err            <= 1'b0;
            data_dup           <= 1'b0;
            payload            <= '0;
            ack_received       <= 1'b0;
            ack_seqNum         <= 1'b0;
            ready_received     <= 1'b0;
            game_lost_received <= 1'b0;
        end else begin
            pkt_valid          <= 1'b0;
            pkt_err            <= 1'b0;
            data_dup           <= 1'b0;
            ack_received       <= 1'b0;
            ready_received     <= 1'b0;
            game_lost_received <= 1'b0;

            case (state)
                S_HUNT: begin
                    // Cleared here and left untouched until HUNT is re-entered, so every sync needs 4 fresh bits.
                    if (sync_next == SYNC) begin
                        state   <= S_HEADER;
                        cnt     <= '0;
                        sync_sr <= 4'd0;
                    end else begin
                        sync_sr <= sync_next;
                    end
                end

                S_HEADER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt != HDR_LAST) begin
                        hdr_type <= {hdr_type[1:0], serial_in_h};
                    end else begin
                        hdr_seq <= serial_in_h;
                        cnt     <= '0;
                        case (hdr_type)
                            T_ACK, T_READY, T_LOST: begin
                                state              <= S_HUNT;
                                pkt_valid          <= 1'b1;
                                pkt_type           <= hdr_type;
                                pkt_seq            <= serial_in_h;
                                ack_received       <= (hdr_type == T_ACK);
                                ready_received     <= (hdr_type == T_READY);
                                game_lost_received <= (hdr_type == T_LOST);
                                if (hdr_type == T_ACK) begin
                                    ack_seqNum <= serial_in_h;
                                end
                            end
                            T_DATA: begin
                                state    <= S_PAYLOAD;
                                lane_par <= 4'd0;
                            end
                            default: begin
                                state   <= S_HUNT;
                                pkt_err <= 1'b1;
                            end
                        endcase
                    end
                end

                S_PAYLOAD: begin
                    // Shift in from the top: after DATA_CYCLES cycles nibble i lands at bits [4i+3:4i].
                    staging  <= {lanes, staging[PW-1:4]};
                    lane_par <= lane_par ^ lanes;
                    cnt      <= cnt + 1'b1;
                    if (cnt == PAY_LAST) begin
                        state <= S_PARITY;
                    end
                end

                S_PARITY: begin
                    state <= S_HUNT;
                    if ((lane_par ^ lanes) == 4'd0) begin
                        pkt_valid <= 1'b1;
                        pkt_type  <= T_DATA;
                        pkt_seq   <= hdr_seq;
                        if (have_data && (hdr_seq == last_data_seq)) begin
                            data_dup <= 1'b1;
                        end else begin
                            payload       <= staging;
                            last_data_seq <= hdr_seq;
                            have_data     <= 1'b1;
                        end
                    end else begin
                        pkt_err <= 1'b1;
                    end
                end

                default: state <= S_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_network_receiver.sv
// Bench for network_receiver with DATA_CYCLES=4: table of packets plus reset-abort sequence,
// expected pulses queued at send time and matched (including cycle) when the DUT pulses.
module tb_network_receiver;

    localparam int DC = 4;
    localparam int PW = 4 * DC;

    localparam logic [2:0] T_ACK   = 3'b001;
    localparam logic [2:0] T_READY = 3'b010;
    localparam logic [2:0] T_LOST  = 3'b011;
    localparam logic [2:0] T_DATA  = 3'b100;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          h, d0, d1, d2, d3;
    logic          pkt_valid, pkt_seq, pkt_err, data_dup;
    logic [2:0]    pkt_type;
    logic [PW-1:0] payload;
    logic          ack_received, ack_seqNum, ready_received, game_lost_received, rx_busy;

    network_receiver #(.DATA_CYCLES(DC), .SYNC(4'b1011)) dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .serial_in_h        (h),
        .serial_in_0        (d0),
        .serial_in_1        (d1),
        .serial_in_2        (d2),
        .serial_in_3        (d3),
        .pkt_valid          (pkt_valid),
        .pkt_type           (pkt_type),
        .pkt_seq            (pkt_seq),
        .pkt_err            (pkt_err),
        .data_dup           (data_dup),
        .payload            (payload),
        .ack_received       (ack_received),
        .ack_seqNum         (ack_seqNum),
        .ready_received     (ready_received),
        .game_lost_received (game_lost_received),
        .rx_busy            (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            exp_cyc;
        logic          valid, err, dup, ack, rdy, lost;
        logic [2:0]    typ;
        logic          seq, ack_seq;
        logic [PW-1:0] pay;
    } exp_t;

    typedef struct {
        logic [2:0]    typ;
        logic          seq;
        logic [PW-1:0] pay;
        logic [3:0]    flip;
        logic          e_good;
        logic          e_dup;
        logic [PW-1:0] e_pay;
    } vec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [2:0] m_type = 3'd0;
    logic       m_seq  = 1'b0;
    logic       m_ack  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (pkt_valid | pkt_err | ack_received | ready_received | game_lost_received) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_cycle", cyc, e.exp_cyc);
                chk("pkt_valid", pkt_valid, e.valid);
                chk("pkt_err", pkt_err, e.err);
                chk("data_dup", data_dup, e.dup);
                chk("ack_received", ack_received, e.ack);
                chk("ready_received", ready_received, e.rdy);
                chk("game_lost_received", game_lost_received, e.lost);
                chk("pkt_type", pkt_type, e.typ);
                chk("pkt_seq", pkt_seq, e.seq);
                chk("ack_seqNum", ack_seqNum, e.ack_seq);
                chk("payload", payload, e.pay);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
            chk("missed_pulse", cyc, sbq[0].exp_cyc);
            void'(sbq.pop_front());
        end
    end

    task automatic drive(input logic hb, input logic [3:0] ln);
        @(posedge clk);
        #1;
        h = hb;
        {d3, d2, d1, d0} = ln;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom));
    endtask

    task automatic send_sync(output int t);
        drive(1'b1, 4'($urandom));
        @(negedge clk);
        chk("rx_busy_hunt", rx_busy, 1'b0);
        drive(1'b0, 4'($urandom));
        drive(1'b1, 4'($urandom));
        drive(1'b1, 4'($urandom));
        t = cyc;
    endtask

    task automatic send_hdr(input logic [2:0] ty, input logic s);
        logic [2:0] tt;
        tt = ty;
        drive(tt[2], 4'($urandom));
        @(negedge clk);
        chk("rx_busy_header", rx_busy, 1'b1);
        drive(tt[1], 4'($urandom));
        drive(tt[0], 4'($urandom));
        drive(s, 4'($urandom));
    endtask

    task automatic send_body(input logic [PW-1:0] p, input logic [3:0] flip);
        logic [3:0] par;
        par = 4'd0;
        for (int i = 0; i < DC; i++) begin
            par = par ^ p[4*i +: 4];
            drive(1'($urandom_range(0, 1)), p[4*i +: 4]);
        end
        drive(1'($urandom_range(0, 1)), par ^ flip);
    endtask

    task automatic send_pkt(input vec_t v);
        int   t;
        exp_t e;
        send_sync(t);
        if (v.e_good) begin
            m_type = v.typ;
            m_seq  = v.seq;
            if (v.typ == T_ACK) m_ack = v.seq;
        end
        e.exp_cyc = (v.typ == T_DATA) ? t + 6 + DC : t + 5;
        e.valid   = v.e_good;
        e.err     = !v.e_good;
        e.dup     = v.e_dup;
        e.ack     = v.e_good && (v.typ == T_ACK);
        e.rdy     = v.e_good && (v.typ == T_READY);
        e.lost    = v.e_good && (v.typ == T_LOST);
        e.typ     = m_type;
        e.seq     = m_seq;
        e.ack_seq = m_ack;
        e.pay     = v.e_pay;
        sbq.push_back(e);
        send_hdr(v.typ, v.seq);
        if (v.typ == T_DATA) send_body(v.pay, v.flip);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pkt_valid"}, pkt_valid, 1'b0);
        chk({tag, "_pkt_err"}, pkt_err, 1'b0);
        chk({tag, "_pkt_type"}, pkt_type, 3'd0);
        chk({tag, "_pkt_seq"}, pkt_seq, 1'b0);
        chk({tag, "_data_dup"}, data_dup, 1'b0);
        chk({tag, "_payload"}, payload, '0);
        chk({tag, "_ack"}, {ack_received, ack_seqNum}, 2'b00);
        chk({tag, "_ready_lost"}, {ready_received, game_lost_received}, 2'b00);
        chk({tag, "_rx_busy"}, rx_busy, 1'b0);
    endtask

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{T_ACK,   1'b1, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000};
        vt[1]  = '{T_DATA,  1'b0, 16'h0F5A, 4'h0, 1'b1, 1'b0, 16'h0F5A};
        vt[2]  = '{T_DATA,  1'b0, 16'h0F5A, 4'h0, 1'b1, 1'b1, 16'h0F5A};
        vt[3]  = '{T_DATA,  1'b1, 16'h1234, 4'h0, 1'b1, 1'b0, 16'h1234};
        vt[4]  = '{T_DATA,  1'b0, 16'hABCD, 4'h4, 1'b0, 1'b0, 16'h1234};
        vt[5]  = '{3'b111,  1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h1234};
        vt[6]  = '{T_READY, 1'b1, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h1234};
        vt[7]  = '{T_LOST,  1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h1234};
        vt[8]  = '{T_DATA,  1'b0, 16'hBEEF, 4'h0, 1'b1, 1'b0, 16'hBEEF};
        vt[9]  = '{3'b000,  1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 16'hBEEF};
        vt[10] = '{T_ACK,   1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'hBEEF};
        vt[11] = '{T_DATA,  1'b0, 16'hCAFE, 4'h9, 1'b0, 1'b0, 16'hBEEF};
        vt[12] = '{T_DATA,  1'b1, 16'h5555, 4'h0, 1'b1, 1'b0, 16'h5555};
        vt[13] = '{T_DATA,  1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b1, 16'h5555};

        rst_l = 1'b0;
        h = 1'b0;
        {d3, d2, d1, d0} = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_l = 1'b1;
        idle(3);

        for (int i = 0; i < 14; i++) begin
            send_pkt(vt[i]);
            // Packet after the unknown type starts on the very first HUNT cycle.
            if (i != 5) idle(int'($urandom_range(0, 2)));
        end

        // Reset during the second payload cycle aborts the packet silently.
        begin
            int t;
            send_sync(t);
            send_hdr(T_DATA, 1'b1);
            drive(1'b0, 4'h3);
            drive(1'b0, 4'h7);
            #2 rst_l = 1'b0;
            @(negedge clk);
            chk_all_zero("midreset");
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_all_zero("midreset_hold");
            @(posedge clk);
            #1 rst_l = 1'b1;
            m_type = 3'd0;
            m_seq  = 1'b0;
            m_ack  = 1'b0;
            idle(2);
        end
        send_pkt('{T_ACK,  1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 16'h0000});
        // have_data was cleared, so seq 0 matching last_data_seq is not a duplicate.
        send_pkt('{T_DATA, 1'b0, 16'h00F0, 4'h0, 1'b1, 1'b0, 16'h00F0});

        for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (sbq.size() != 0) chk("drain", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
